// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared types and constants for the instruction fetch sequencer.
//   fetch_state_t : sequencer FSM states
//   HALT_BYTE     : byte value that, repeated across a whole word, halts the run
package fetch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CHECK,
      EXEC,
      DONE
   } fetch_state_t;

   localparam logic [7:0] HALT_BYTE = 8'h00;

endpackage

// File: rtl/instr_fetch_seq_byte_assembler.sv
// byte_assembler -- walks one instruction's bytes out of byte-wide memory.
// While run=1 the counter k steps 0..NBYTES and then parks at NBYTES+1.
// Address base+k is offered for k<NBYTES; the byte returned one cycle later
// lands in word[8(k-1)+:8] for 1<=k<=NBYTES. Dropping run rewinds k to 0.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   run            : step the counter this cycle
//   base           : byte address of byte 0 (PC width, wrapped to IADDR_W)
//   rdata          : memory read data (one-cycle latency)
//   addr, addr_vld : memory address and its qualifier
//   k              : current byte counter
//   last           : final byte is captured this cycle
//   full           : word is complete once this cycle's capture lands
//   word_nxt       : word including this cycle's capture
module byte_assembler
   import fetch_pkg::*;
#(
   parameter int NBYTES  = 4,
   parameter int PC_W    = 32,
   parameter int IADDR_W = 10,
   parameter int KW      = $clog2(NBYTES + 2)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   input  logic [PC_W-1:0]       base,
   input  logic [7:0]            rdata,
   output logic [IADDR_W-1:0]    addr,
   output logic                  addr_vld,
   output logic [KW-1:0]         k,
   output logic                  last,
   output logic                  full,
   output logic [8*NBYTES-1:0]   word_nxt
);

   localparam logic [KW-1:0] K_LAST = KW'(NBYTES);

   logic [8*NBYTES-1:0] word;

   always_ff @(posedge clk) begin
      if (rst) begin
         k    <= '0;
         word <= '0;
      end else begin
         if (!run)
            k <= '0;
         else if (k <= K_LAST)
            k <= k + KW'(1);
         word <= word_nxt;
      end
   end

   // byte requested at k-1 comes back now
   always_comb begin
      word_nxt = word;
      for (int b = 0; b < NBYTES; b++)
         if (run && k == KW'(b + 1))
            word_nxt[8*b +: 8] = rdata;
   end

   assign addr     = IADDR_W'(base + PC_W'(k));
   assign addr_vld = run && (k < K_LAST);
   assign last     = run && (k == K_LAST);
   assign full     = run && (k >= K_LAST);

endmodule

// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq -- instruction fetch sequencer for the FakeCPU core.
// Reads INSTR_BYTES bytes little-endian from byte-wide instruction memory
// starting at the PC, writes PC+INSTR_BYTES back once per instruction and
// offers the word to decode on a valid/ready handshake. An all-zero word
// halts the run (finish) until go drops.
// Optional feature macro: FETCH_PREFETCH_EN -- while decode holds an
// instruction, a shadow assembler fetches the next one; an unredirected,
// complete shadow skips the FETCH phase after the handshake.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   go                  : run enable; low aborts to IDLE
//   finish              : halt reached, held while go=1
//   imem_addr/imem_rdata: instruction memory byte port (1-cycle read)
//   pc_rdata            : current PC value
//   pc_wdata/pc_wren    : PC write port, one pulse per instruction
//   pc_redirect         : decode wrote the PC (used only with prefetch)
//   instr/instr_valid   : assembled instruction offered to decode
//   instr_ready         : decode consumed the instruction
module instr_fetch_seq
   import fetch_pkg::*;
#(
   parameter int INSTR_BYTES = 4,
   parameter int PC_W        = 32,
   parameter int IADDR_W     = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     go,
   output logic                     finish,
   output logic [IADDR_W-1:0]       imem_addr,
   input  logic [7:0]               imem_rdata,
   input  logic [PC_W-1:0]          pc_rdata,
   output logic [PC_W-1:0]          pc_wdata,
   output logic                     pc_wren,
   input  logic                     pc_redirect,
   output logic [8*INSTR_BYTES-1:0] instr,
   output logic                     instr_valid,
   input  logic                     instr_ready
);

   localparam int                KW        = $clog2(INSTR_BYTES + 2);
   localparam int                IW        = 8 * INSTR_BYTES;
   localparam logic [PC_W-1:0]   STEP      = PC_W'(INSTR_BYTES);
   localparam logic [IW-1:0]     HALT_WORD = {INSTR_BYTES{HALT_BYTE}};

   fetch_state_t         state, state_nxt;
   logic [PC_W-1:0]      base;
   logic [PC_W-1:0]      m_base;
   logic                 m_run, m_addr_vld, m_last, m_full;
   logic [IADDR_W-1:0]   m_addr;
   logic [KW-1:0]        m_k;
   logic [IW-1:0]        m_word_nxt;
   logic                 is_halt, xfer, pf_take, pf_hit;
   logic                 unused_sig;

   // ---------------- main assembler ----------------
   assign m_run  = (state == FETCH);
   // base is only registered at the end of k=0, so byte 0 reads the PC directly
   assign m_base = (m_k == '0) ? pc_rdata : base;

   byte_assembler #(
      .NBYTES (INSTR_BYTES),
      .PC_W   (PC_W),
      .IADDR_W(IADDR_W),
      .KW     (KW)
   ) u_main (
      .clk     (clk),
      .rst     (rst),
      .run     (m_run),
      .base    (m_base),
      .rdata   (imem_rdata),
      .addr    (m_addr),
      .addr_vld(m_addr_vld),
      .k       (m_k),
      .last    (m_last),
      .full    (m_full),
      .word_nxt(m_word_nxt)
   );

   assign is_halt = (instr == HALT_WORD);
   // instr_valid is high for the whole of EXEC, so ready there is the transfer
   assign xfer    = (state == EXEC) && instr_ready;

`ifdef FETCH_PREFETCH_EN
   // ---------------- shadow assembler ----------------
   logic                 s_run, s_addr_vld, s_last, s_full, stale;
   logic [PC_W-1:0]      s_base;
   logic [IADDR_W-1:0]   s_addr;
   logic [KW-1:0]        s_k;
   logic [IW-1:0]        s_word_nxt;

   assign s_run  = (state == EXEC);
   assign s_base = base + STEP;

   byte_assembler #(
      .NBYTES (INSTR_BYTES),
      .PC_W   (PC_W),
      .IADDR_W(IADDR_W),
      .KW     (KW)
   ) u_shadow (
      .clk     (clk),
      .rst     (rst),
      .run     (s_run),
      .base    (s_base),
      .rdata   (imem_rdata),
      .addr    (s_addr),
      .addr_vld(s_addr_vld),
      .k       (s_k),
      .last    (s_last),
      .full    (s_full),
      .word_nxt(s_word_nxt)
   );

   // a redirect in the handshake cycle itself also spoils the shadow
   assign pf_take = s_full && !stale && !pc_redirect;

   always_ff @(posedge clk) begin
      if (rst) begin
         stale  <= 1'b0;
         pf_hit <= 1'b0;
      end else begin
         stale  <= (state == EXEC) && (stale || pc_redirect);
         pf_hit <= go && xfer && pf_take;
      end
   end

   // FETCH and EXEC are exclusive, so the two address sources never collide
   assign imem_addr  = m_addr_vld ? m_addr : (s_addr_vld ? s_addr : '0);
   assign unused_sig = ^{m_full, m_word_nxt, s_last, s_k};
`else
   assign pf_take    = 1'b0;
   assign pf_hit     = 1'b0;
   assign imem_addr  = m_addr_vld ? m_addr : '0;
   assign unused_sig = ^{m_full, m_word_nxt, pc_redirect};
`endif

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (!finish) state_nxt = FETCH;
         FETCH: if (m_last) state_nxt = CHECK;
         CHECK: state_nxt = is_halt ? DONE : EXEC;
         EXEC:  if (instr_ready) state_nxt = pf_take ? CHECK : FETCH;
         DONE:  state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
      if (!go)
         state_nxt = IDLE;
   end

   // A prefetch hit advances base at the handshake, so base+STEP is the
   // correct write value in both the FETCH and the CHECK pulse.
   assign pc_wren  = !rst && go &&
                     ((state == FETCH && m_last) || (state == CHECK && pf_hit));
   assign pc_wdata = pc_wren ? (base + STEP) : '0;

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         base        <= '0;
         instr       <= '0;
         finish      <= 1'b0;
         instr_valid <= 1'b0;
      end else begin
         finish      <= go && ((state == CHECK && is_halt) || (state == DONE));
         instr_valid <= go && ((state == CHECK && !is_halt) ||
                               (state == EXEC && !instr_ready));
         if (state == FETCH && m_k == '0)
            base <= pc_rdata;
         for (int b = 0; b < INSTR_BYTES; b++)
            if (state == FETCH && m_k == KW'(b + 1))
               instr[8*b +: 8] <= imem_rdata;
`ifdef FETCH_PREFETCH_EN
         if (go && xfer && pf_take) begin
            instr <= s_word_nxt;
            base  <= base + STEP;
         end
`endif
      end
   end

endmodule
